booth_seq_ctrl: RTL and testbench

BOOTH_SEQ_CTRL -- requirements
Module: booth_seq_ctrl

---
 rtl/booth_seq_ctrl_pkg.sv | 15 +
 rtl/booth_seq_ctrl.sv | 126 ++++++++++++
 tb/tb_booth_seq_ctrl.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/booth_seq_ctrl_pkg.sv
// Shared definitions for the sequential Booth multiplier controller:
// FSM state encoding and the width of the external shared ALU.
package booth_seq_ctrl_pkg;

  localparam int ALU_W = 32;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    ARITH = 3'd2,
    SHIFT = 3'd3,
    DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/booth_seq_ctrl.sv
// Radix-2 Booth sequential multiplier; the add/subtract is borrowed from an
// external shared ALU through a req/gnt handshake.
module booth_seq_ctrl
  import booth_seq_ctrl_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic signed [WIDTH-1:0]   mcand,
  input  logic signed [WIDTH-1:0]   mplier,
  output logic                      busy,
  output logic                      done,
  output logic signed [2*WIDTH-1:0] product,
  output logic                      alu_req,
  input  logic                      alu_gnt,
  output logic signed [ALU_W-1:0]   alu_in1,
  output logic signed [ALU_W-1:0]   alu_in2,
  output logic                      alu_add_sub,
  input  logic signed [ALU_W-1:0]   alu_out
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t                  state;
  logic signed [WIDTH:0]   a;
  logic [WIDTH-1:0]        q;
  logic                    q_1;
  logic signed [WIDTH-1:0] m;
  logic [CNT_W-1:0]        cnt;

  logic signed [WIDTH:0]   a_sh;
  logic [WIDTH-1:0]        q_sh;
  logic                    alu_unused;

  // Arithmetic right shift of {A,Q,Q_1}; A's sign bit is replicated.
  assign a_sh = {a[WIDTH], a[WIDTH:1]};
  assign q_sh = {a[0], q[WIDTH-1:1]};

  // Only the low WIDTH+1 bits of the ALU result are meaningful here.
  assign alu_unused = &{1'b0, alu_out};

  function automatic logic signed [ALU_W-1:0] sext_a(input logic signed [WIDTH:0] v);
    return ALU_W'(v);
  endfunction

  function automatic logic signed [ALU_W-1:0] sext_m(input logic signed [WIDTH-1:0] v);
    return ALU_W'(v);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      a           <= '0;
      q           <= '0;
      q_1         <= 1'b0;
      m           <= '0;
      cnt         <= '0;
      product     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      alu_req     <= 1'b0;
      alu_in1     <= '0;
      alu_in2     <= '0;
      alu_add_sub <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            m     <= mcand;
            q     <= mplier;
            a     <= '0;
            q_1   <= 1'b0;
            cnt   <= CNT_W'(WIDTH);
            busy  <= 1'b1;
            state <= CHECK;
          end
        end
        CHECK: begin
          // 01 -> add M, 10 -> subtract M; operands held until granted
          if (q[0] != q_1) begin
            alu_req     <= 1'b1;
            alu_in1     <= sext_a(a);
            alu_in2     <= sext_m(m);
            alu_add_sub <= q_1;
            state       <= ARITH;
          end else begin
            state <= SHIFT;
          end
        end
        ARITH: begin
          if (alu_gnt) begin
            a           <= alu_out[WIDTH:0];
            alu_req     <= 1'b0;
            alu_in1     <= '0;
            alu_in2     <= '0;
            alu_add_sub <= 1'b0;
            state       <= SHIFT;
          end
        end
        SHIFT: begin
          a   <= a_sh;
          q   <= q_sh;
          q_1 <= q[0];
          cnt <= cnt - CNT_W'(1);
          // Last shift: publish the result together with the done pulse.
          if (cnt == CNT_W'(1)) begin
            product <= {a_sh[WIDTH-1:0], q_sh};
            done    <= 1'b1;
            state   <= DONE;
          end else begin
            state <= CHECK;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_seq_ctrl.sv
// Directed bench for booth_seq_ctrl: table of operand pairs with expected
// products/latencies, plus hand-written stall, restart and reset sequences.
module tb_booth_seq_ctrl;

  localparam int W = 16;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  start;
  logic signed [W-1:0]   mcand;
  logic signed [W-1:0]   mplier;
  logic                  busy;
  logic                  done;
  logic signed [2*W-1:0] product;
  logic                  alu_req;
  logic                  alu_gnt;
  logic signed [31:0]    alu_in1;
  logic signed [31:0]    alu_in2;
  logic                  alu_add_sub;
  logic signed [31:0]    alu_out;

  booth_seq_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .mcand(mcand), .mplier(mplier),
    .busy(busy), .done(done), .product(product),
    .alu_req(alu_req), .alu_gnt(alu_gnt), .alu_in1(alu_in1), .alu_in2(alu_in2),
    .alu_add_sub(alu_add_sub), .alu_out(alu_out)
  );

  always #5 clk = ~clk;

  // External shared ALU
  assign alu_out = alu_add_sub ? (alu_in1 + alu_in2) : (alu_in1 - alu_in2);

  int checks = 0;
  int errors = 0;
  int idle_viol = 0;

  always @(negedge clk)
    if (!rst && !alu_req && (alu_in1 != 0 || alu_in2 != 0 || alu_add_sub))
      idle_viol++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic signed [W-1:0] mc;
    logic signed [W-1:0] mp;
    int                  stall;
    int                  poke;
    logic [31:0]         prod;
    int                  lat;
    logic                req;
  } vec_t;

  vec_t vecs[11];

  task automatic run_op(input logic signed [W-1:0] mc, input logic signed [W-1:0] mp,
                        input int stall, input int poke,
                        output logic [31:0] prod, output int lat, output logic saw_req,
                        output int unstable, output logic done_after, output logic busy_after);
    int stall_left;
    logic cap;
    logic [64:0] held;
    lat = 0; saw_req = 1'b0; unstable = 0; stall_left = stall; cap = 1'b0; held = '0;
    @(negedge clk);
    mcand = mc; mplier = mp; start = 1'b1;
    @(posedge clk); #1;
    for (int cyc = 1; cyc <= 200; cyc++) begin
      if (cyc == poke) begin
        start = 1'b1; mcand = -16'sd5; mplier = 16'sd9;
      end else begin
        start = 1'b0;
      end
      if (alu_req) saw_req = 1'b1;
      if (alu_req && stall_left > 0) begin
        if (!cap) begin
          cap = 1'b1;
          held = {alu_in1, alu_in2, alu_add_sub};
        end else if ({alu_in1, alu_in2, alu_add_sub} !== held) begin
          unstable++;
        end
        alu_gnt = 1'b0;
        stall_left--;
      end else begin
        alu_gnt = 1'b1;
      end
      if (done) begin
        lat = cyc;
        break;
      end
      @(posedge clk); #1;
    end
    alu_gnt = 1'b1;
    prod = product;
    // A start coinciding with the done cycle must be dropped.
    start = 1'b1; mcand = mc; mplier = mp;
    @(posedge clk); #1;
    start = 1'b0;
    done_after = done;
    busy_after = busy;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] prod;
    int lat, unstable;
    logic saw_req, done_after, busy_after;

    vecs[0]  = '{16'sd3,      16'sd5,      0, 5,  32'h0000000F, 37, 1'b1};
    vecs[1]  = '{16'sh8000,   16'sh8000,   0, 0,  32'h40000000, 34, 1'b1};
    vecs[2]  = '{16'sd1234,   16'sd0,      0, 0,  32'h00000000, 33, 1'b0};
    vecs[3]  = '{16'sd7,      -16'sd3,     0, 0,  32'hFFFFFFEB, 36, 1'b1};
    vecs[4]  = '{16'sd7,      -16'sd3,     4, 0,  32'hFFFFFFEB, 40, 1'b1};
    vecs[5]  = '{-16'sd1,     -16'sd1,     0, 0,  32'h00000001, 34, 1'b1};
    vecs[6]  = '{16'sd32767,  16'sd32767,  0, 10, 32'h3FFF0001, 35, 1'b1};
    vecs[7]  = '{16'sh8000,   16'sd32767,  0, 0,  32'hC0008000, 35, 1'b1};
    vecs[8]  = '{16'sd100,    -16'sd1,     0, 0,  32'hFFFFFF9C, 34, 1'b1};
    vecs[9]  = '{16'sd0,      16'sh8000,   0, 0,  32'h00000000, 34, 1'b1};
    vecs[10] = '{16'sd12345,  16'sd2,      0, 20, 32'h00006072, 35, 1'b1};

    rst = 1'b1; start = 1'b0; alu_gnt = 1'b1; mcand = '0; mplier = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_product", product, 32'd0);
    check("reset_alu_req", {31'd0, alu_req}, 32'd0);
    @(negedge clk) rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      run_op(vecs[i].mc, vecs[i].mp, vecs[i].stall, vecs[i].poke,
             prod, lat, saw_req, unstable, done_after, busy_after);
      check($sformatf("v%0d_product", i), prod, vecs[i].prod);
      check($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      check($sformatf("v%0d_alu_req_seen", i), {31'd0, saw_req}, {31'd0, vecs[i].req});
      check($sformatf("v%0d_operands_stable", i), unstable, 32'd0);
      check($sformatf("v%0d_done_busy_after", i), {30'd0, done_after, busy_after}, 32'd0);
    end

    // Product must persist while idle.
    repeat (4) @(posedge clk);
    #1;
    check("product_hold", product, 32'h00006072);

    // Reset while in the first SHIFT of 3*5 (cycle 3: CHECK, ARITH, SHIFT).
    @(negedge clk);
    mcand = 16'sd3; mplier = 16'sd5; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("pre_reset_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    check("async_reset_busy", {31'd0, busy}, 32'd0);
    check("async_reset_product", product, 32'd0);
    check("async_reset_alu_req", {31'd0, alu_req}, 32'd0);
    done_after = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      if (done) done_after = 1'b1;
    end
    check("reset_no_done", {31'd0, done_after}, 32'd0);
    rst = 1'b0;

    run_op(16'sd3, 16'sd5, 0, 0, prod, lat, saw_req, unstable, done_after, busy_after);
    check("post_reset_product", prod, 32'h0000000F);
    check("post_reset_latency", lat, 32'd37);

    check("alu_inputs_zero_when_idle", idle_viol, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
